// File: rtl/i2c_target.sv
// I2C target with an NREG x 8 register bank, a write pointer, auto-increment
// and a combinational local read port. Bus pins are oversampled on clk.
module i2c_target #(
    parameter logic [6:0]  DEV_ADDR = 7'h50,
    parameter int unsigned NREG     = 16,
    localparam int unsigned AW      = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          scl_i,
    input  logic          sda_i,
    output logic          sda_oe_o,
    input  logic [AW-1:0] loc_addr_i,
    output logic [7:0]    loc_data_o,
    output logic          busy_o,
    output logic          wr_stb_o,
    output logic [AW-1:0] wr_addr_o
);

    typedef enum logic [3:0] {
        StIdle, StAddr, StAddrAck, StPtr, StPtrAck,
        StWdata, StWdataAck, StRdata, StRdataAck, StWaitStop
    } state_e;

    state_e        r_state, w_state_d;
    logic [2:0]    r_scl_sync, r_sda_sync;
    logic [3:0]    r_cnt, w_cnt_d;
    logic [7:0]    r_shift, w_shift_d;
    logic [AW-1:0] r_ptr, w_ptr_d;
    logic          r_oe, w_oe_d;
    logic          r_busy, w_busy_d;
    logic          w_commit;
    logic [7:0]    r_bank [NREG];

    logic w_scl, w_sda, w_scl_rise, w_scl_fall, w_start, w_stop, w_byte_done;
    logic [7:0] w_bank_at_ptr;

    // Stages [0],[1] synchronise; [2] holds the previous synced level for edges.
    assign w_scl       = r_scl_sync[1];
    assign w_sda       = r_sda_sync[1];
    assign w_scl_rise  = w_scl & ~r_scl_sync[2];
    assign w_scl_fall  = ~w_scl & r_scl_sync[2];
    assign w_start     = w_scl & r_sda_sync[2] & ~w_sda;
    assign w_stop      = w_scl & ~r_sda_sync[2] & w_sda;
    assign w_byte_done = (r_cnt == 4'd8);
    assign w_bank_at_ptr = r_bank[r_ptr];

    assign sda_oe_o   = r_oe;
    assign busy_o     = r_busy;
    assign loc_data_o = r_bank[loc_addr_i];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        if (w_start) begin
            w_state_d = StAddr;
        end else if (w_stop) begin
            w_state_d = StIdle;
        end else if (w_scl_rise) begin
            if (r_state == StRdataAck && w_sda) w_state_d = StWaitStop;
        end else if (w_scl_fall) begin
            case (r_state)
                StAddr: begin
                    if (w_byte_done) begin
                        w_state_d = (r_shift[7:1] == DEV_ADDR) ? StAddrAck : StWaitStop;
                    end
                end
                StAddrAck:  w_state_d = r_shift[0] ? StRdata : StPtr;
                StPtr:      if (w_byte_done) w_state_d = StPtrAck;
                StPtrAck:   w_state_d = StWdata;
                StWdata:    if (w_byte_done) w_state_d = StWdataAck;
                StWdataAck: w_state_d = StWdata;
                StRdata:    if (w_byte_done) w_state_d = StRdataAck;
                StRdataAck: w_state_d = StRdata;
                default:    w_state_d = r_state;
            endcase
        end
    end

    always_comb begin
        w_oe_d    = r_oe;
        w_busy_d  = r_busy;
        w_cnt_d   = r_cnt;
        w_shift_d = r_shift;
        w_ptr_d   = r_ptr;
        w_commit  = 1'b0;
        if (w_start) begin
            w_cnt_d = 4'd0;
            w_oe_d  = 1'b0;
        end else if (w_stop) begin
            w_cnt_d  = 4'd0;
            w_oe_d   = 1'b0;
            w_busy_d = 1'b0;
        end else if (w_scl_rise) begin
            case (r_state)
                StAddr, StPtr, StWdata: begin
                    if (!w_byte_done) begin
                        w_shift_d = {r_shift[6:0], w_sda};
                        w_cnt_d   = r_cnt + 4'd1;
                    end
                end
                StRdata: if (!w_byte_done) w_cnt_d = r_cnt + 4'd1;
                StRdataAck: if (!w_sda) w_ptr_d = r_ptr + AW'(1);
                default: ;
            endcase
        end else if (w_scl_fall) begin
            case (r_state)
                StAddr: begin
                    if (w_byte_done && r_shift[7:1] == DEV_ADDR) begin
                        w_oe_d   = 1'b1;
                        w_busy_d = 1'b1;
                    end
                end
                StAddrAck: begin
                    w_cnt_d = 4'd0;
                    if (r_shift[0]) begin
                        w_shift_d = w_bank_at_ptr;
                        w_oe_d    = ~w_bank_at_ptr[7];
                    end else begin
                        w_oe_d = 1'b0;
                    end
                end
                StPtr: begin
                    if (w_byte_done) begin
                        w_ptr_d = r_shift[AW-1:0];
                        w_oe_d  = 1'b1;
                    end
                end
                StWdata: begin
                    if (w_byte_done) begin
                        w_commit = 1'b1;
                        w_ptr_d  = r_ptr + AW'(1);
                        w_oe_d   = 1'b1;
                    end
                end
                StPtrAck, StWdataAck: begin
                    w_oe_d  = 1'b0;
                    w_cnt_d = 4'd0;
                end
                StRdata: begin
                    // Bit 7 went out at load; each later fall shifts the next bit up.
                    if (w_byte_done) begin
                        w_oe_d = 1'b0;
                    end else if (r_cnt != 4'd0) begin
                        w_shift_d = {r_shift[6:0], 1'b0};
                        w_oe_d    = ~r_shift[6];
                    end
                end
                StRdataAck: begin
                    w_cnt_d   = 4'd0;
                    w_shift_d = w_bank_at_ptr;
                    w_oe_d    = ~w_bank_at_ptr[7];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_scl_sync <= 3'b111;
            r_sda_sync <= 3'b111;
            r_cnt      <= 4'd0;
            r_shift    <= 8'h00;
            r_ptr      <= '0;
            r_oe       <= 1'b0;
            r_busy     <= 1'b0;
            wr_stb_o   <= 1'b0;
            wr_addr_o  <= '0;
            for (int unsigned i = 0; i < NREG; i++) r_bank[i] <= 8'h00;
        end else begin
            r_scl_sync <= {r_scl_sync[1:0], scl_i};
            r_sda_sync <= {r_sda_sync[1:0], sda_i};
            r_cnt      <= w_cnt_d;
            r_shift    <= w_shift_d;
            r_ptr      <= w_ptr_d;
            r_oe       <= w_oe_d;
            r_busy     <= w_busy_d;
            wr_stb_o   <= w_commit;
            if (w_commit) begin
                r_bank[r_ptr] <= r_shift;
                wr_addr_o     <= r_ptr;
            end
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// Bus-level bench: a bit-banged master drives the target; write strobes and
// bus responses are checked against expectations queued when stimulus is issued.
module tb_i2c_target;

    localparam int Q = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       sda_w;
    logic       sda_oe_o;
    logic [3:0] loc_addr_i = 4'd0;
    logic [7:0] loc_data_o;
    logic       busy_o;
    logic       wr_stb_o;
    logic [3:0] wr_addr_o;

    int n_vec = 0;
    int n_err = 0;
    int exp_wr[$];
    int exp_bus[$];
    int obs_bus[$];
    string obs_tag[$];
    int oe_cnt = 0;
    int busy_cnt = 0;

    assign sda_w = m_sda & ~sda_oe_o;

    i2c_target #(.DEV_ADDR(7'h50), .NREG(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .scl_i     (m_scl),
        .sda_i     (sda_w),
        .sda_oe_o  (sda_oe_o),
        .loc_addr_i(loc_addr_i),
        .loc_data_o(loc_data_o),
        .busy_o    (busy_o),
        .wr_stb_o  (wr_stb_o),
        .wr_addr_o (wr_addr_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Write-strobe monitor: every pulse must match the next queued address.
    always @(negedge clk) begin
        if (wr_stb_o) begin
            if (exp_wr.size() == 0) check("unexpected wr_stb", 1, 0);
            else check("wr_addr", int'(wr_addr_o), exp_wr.pop_front());
        end
    end

    // Bus monitor: compares each observed ACK bit / read byte with its expectation.
    always @(negedge clk) begin
        if (obs_bus.size() > 0) begin
            if (exp_bus.size() == 0) check("unexpected bus obs", 1, 0);
            else check(obs_tag.pop_front(), obs_bus.pop_front(), exp_bus.pop_front());
        end
    end

    always @(posedge clk) begin
        if (sda_oe_o) oe_cnt <= oe_cnt + 1;
        if (busy_o) busy_cnt <= busy_cnt + 1;
    end

    initial begin
        #600us;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic bus_start();
        m_sda = 1'b1; hold(Q);
        m_scl = 1'b1; hold(Q);
        m_sda = 1'b0; hold(Q);
        m_scl = 1'b0; hold(Q);
    endtask

    task automatic bus_stop();
        m_sda = 1'b0; hold(Q);
        m_scl = 1'b1; hold(Q);
        m_sda = 1'b1; hold(Q);
    endtask

    task automatic write_bit(input logic b);
        m_sda = b;    hold(Q);
        m_scl = 1'b1; hold(Q);
        m_scl = 1'b0; hold(Q);
    endtask

    task automatic read_bit(output logic b);
        m_sda = 1'b1; hold(Q);
        m_scl = 1'b1; hold(Q / 2);
        b = sda_w;    hold(Q / 2);
        m_scl = 1'b0; hold(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, input logic exp_ack);
        logic a;
        exp_bus.push_back(int'(exp_ack));
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(a);
        obs_tag.push_back("ack");
        obs_bus.push_back(int'(a));
    endtask

    task automatic read_byte(input logic [7:0] exp_d, input logic m_ack);
        logic [7:0] d;
        logic b;
        exp_bus.push_back(int'(exp_d));
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        obs_tag.push_back("read byte");
        obs_bus.push_back(int'(d));
        write_bit(m_ack);
    endtask

    task automatic check_reg(input int idx, input int exp);
        loc_addr_i = 4'(idx);
        #1;
        check($sformatf("bank[%0d]", idx), int'(loc_data_o), exp);
    endtask

    initial begin
        int oe0, busy0;
        bit seen;

        // Reset state
        hold(3);
        check("reset sda_oe", int'(sda_oe_o), 0);
        check("reset busy", int'(busy_o), 0);
        check("reset wr_stb", int'(wr_stb_o), 0);
        check("reset wr_addr", int'(wr_addr_o), 0);
        check_reg(3, 8'h00);
        rst = 1'b1;
        hold(4);

        // Write 5A, C3 from pointer 3
        bus_start();
        write_byte(8'hA0, 1'b0);
        write_byte(8'h03, 1'b0);
        exp_wr.push_back(3);
        write_byte(8'h5A, 1'b0);
        exp_wr.push_back(4);
        write_byte(8'hC3, 1'b0);
        check("busy in write", int'(busy_o), 1);
        bus_stop();
        hold(4);
        check("busy after stop", int'(busy_o), 0);
        check_reg(3, 8'h5A);
        check_reg(4, 8'hC3);

        // Pointer write, repeated START, read two bytes
        bus_start();
        write_byte(8'hA0, 1'b0);
        write_byte(8'h03, 1'b0);
        bus_start();
        write_byte(8'hA1, 1'b0);
        read_byte(8'h5A, 1'b0);
        read_byte(8'hC3, 1'b1);
        hold(4);
        check("oe after nack", int'(sda_oe_o), 0);
        check("busy before stop", int'(busy_o), 1);
        bus_stop();
        hold(4);
        check("busy after read stop", int'(busy_o), 0);

        // Wrong address: never drives, never busy, never writes
        oe0 = oe_cnt;
        busy0 = busy_cnt;
        bus_start();
        write_byte(8'hA2, 1'b1);
        write_byte(8'h05, 1'b1);
        write_byte(8'h99, 1'b1);
        bus_stop();
        hold(4);
        check("wrong addr oe cycles", oe_cnt - oe0, 0);
        check("wrong addr busy cycles", busy_cnt - busy0, 0);
        check_reg(5, 8'h00);

        // Pointer wrap 15 -> 0
        bus_start();
        write_byte(8'hA0, 1'b0);
        write_byte(8'h0F, 1'b0);
        exp_wr.push_back(15);
        write_byte(8'h11, 1'b0);
        exp_wr.push_back(0);
        write_byte(8'h22, 1'b0);
        bus_stop();
        hold(4);
        check_reg(15, 8'h11);
        check_reg(0, 8'h22);

        // STOP after 4 data bits commits nothing
        bus_start();
        write_byte(8'hA0, 1'b0);
        write_byte(8'h07, 1'b0);
        for (int i = 0; i < 4; i++) write_bit(1'b1);
        bus_stop();
        hold(4);
        check("busy after short stop", int'(busy_o), 0);
        check_reg(7, 8'h00);
        check_reg(3, 8'h5A);

        // Reset while the target is ACKing its address
        bus_start();
        for (int i = 7; i >= 0; i--) write_bit(i == 5 || i == 7);
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            if (sda_oe_o) seen = 1'b1;
            else @(posedge clk);
        end
        check("ack before reset", int'(seen), 1);
        #2;
        rst = 1'b0;
        #1;
        check("oe at reset", int'(sda_oe_o), 0);
        check("busy at reset", int'(busy_o), 0);
        check_reg(3, 8'h00);
        m_scl = 1'b1;
        m_sda = 1'b1;
        hold(4);
        rst = 1'b1;
        hold(4);

        // Fresh transaction after reset
        bus_start();
        write_byte(8'hA0, 1'b0);
        write_byte(8'h05, 1'b0);
        exp_wr.push_back(5);
        write_byte(8'h77, 1'b0);
        bus_stop();
        hold(6);
        check_reg(5, 8'h77);

        hold(4);
        check("pending wr_stb expectations", exp_wr.size(), 0);
        check("pending bus expectations", exp_bus.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/i2c_target.md
I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 Parameter DEV_ADDR, default 7'h50: 7-bit bus address this target answers to.
REQ-002 Parameter NREG, default 16: number of 8-bit registers in the internal bank (power of two, at most 256).
REQ-003 clk  input  1: single clock; all state on its rising edge.
REQ-004 rst  input  1: asynchronous, active-low reset.
REQ-005 scl_i  input  1: bus clock pin level, asynchronous to clk.
REQ-006 sda_i  input  1: bus data pin level, asynchronous to clk.
REQ-007 sda_oe_o  output  1: 1 pulls SDA low (open-drain); 0 releases it.
REQ-008 loc_addr_i  input  log2(NREG): local combinational read address into the register bank.
REQ-009 loc_data_o  output  8: bank[loc_addr_i].
REQ-010 busy_o  output  1: high from an addressed START until the following STOP or NACK-idle.
REQ-011 wr_stb_o  output  1: one-cycle pulse when a bus write commits a byte.
REQ-012 wr_addr_o  output  log2(NREG): register index of the last committed write.

Function
REQ-013 scl_i and sda_i shall pass through 2-FF synchronisers, then a third register used for edge detection.
- Edges are evaluated on synchronised levels only.
REQ-014 START shall be detected as synced SDA 1->0 while synced SCL is 1.
- Also detected as repeated START in any state.
- Clears the bit counter, releases sda_oe_o, enters ADDR.
REQ-015 STOP shall be detected as synced SDA 0->1 while synced SCL is 1.
- Valid in any state; enters IDLE and clears busy_o.
REQ-016 FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP.
REQ-017 Data bits shall be sampled MSB first on synced SCL rising edges.
- sda_oe_o shall change only on synced SCL falling edges, except for the release at START/STOP/reset.
REQ-018 ADDR: after 8 bits, {addr[6:0], rw}.
- addr == DEV_ADDR: on the next SCL fall, assert sda_oe_o (ACK), set busy_o, enter ADDR_ACK.
- Otherwise: stay released and enter WAIT_STOP.
REQ-019 ADDR_ACK: release at the SCL fall ending the 9th clock.
- rw = 0: go to PTR.
- rw = 1: load bank[ptr] into the shift register and drive its MSB (oe = ~bit) at that same fall; go to RDATA.
REQ-020 PTR: after 8 bits, ptr <= byte mod NREG; ACK as in REQ-018; then WDATA.
REQ-021 WDATA: after 8 bits, on the ACK fall:
- bank[ptr] <= byte, wr_stb_o pulses one cycle, wr_addr_o <= ptr, ptr <= ptr+1 (wraps NREG-1 -> 0);
- assert ACK, WDATA_ACK, then back to WDATA.
REQ-022 RDATA: bits 6..0 shall be driven on successive SCL falls (oe = ~bit); sda_oe_o is released on the fall after bit 0.
- At the 9th SCL rise, sample master ACK.
- SDA = 0: ptr increments with wrap; next byte loaded and MSB driven on the following fall.
- SDA = 1 (NACK): WAIT_STOP, released.
REQ-023 A repeated START after a PTR write shall keep ptr, so a write-pointer-then-read sequence reads from ptr.
REQ-024 WAIT_STOP shall ignore bits and keep sda_oe_o = 0 until START or STOP.
REQ-025 loc_data_o shall be combinational from the bank.
- A local read of the index committed in the same cycle returns the old value.

Reset
REQ-026 rst low shall asynchronously force:
- state IDLE, sda_oe_o = 0, busy_o = 0, wr_stb_o = 0, wr_addr_o = 0;
- ptr = 0, bit counter = 0, all bank bytes = 8'h00, synchroniser flops = 1 (idle bus).
REQ-027 Reset asserted mid-transfer shall release SDA immediately; after deassertion the target waits for a fresh START.

Verification
REQ-028 Write: START, 0xA0, 0x03, 0x5A, 0xC3, STOP -> three ACKs plus a data ACK; wr_stb_o pulses twice (wr_addr_o 3 then 4); bank[3] = 5A, bank[4] = C3.
REQ-029 Read: START, 0xA0, 0x03, Sr, 0xA1, read 2 bytes (ACK, then NACK), STOP -> bus returns 5A, C3; sda_oe_o is released after NACK; busy_o falls at STOP.
REQ-030 Wrong address: START, 0xA2, ... -> sda_oe_o stays 0 for the whole transfer; no wr_stb_o; busy_o stays 0.
REQ-031 Wrap: write ptr 0x0F, then data 0x11, 0x22 -> bank[15] = 11, bank[0] = 22.
REQ-032 Reset mid-ACK: assert rst while sda_oe_o = 1 -> sda_oe_o = 0 the same instant; the bank reads 00 at loc_addr_i = 3.
REQ-033 STOP inside a data byte after 4 bits -> IDLE; no write committed; bank unchanged.
